mem_stage_unit: RTL and testbench
=================================

Name: mem_stage_unit

Overview:
- MEM stage of the 5-stage pipeline. It sits directly downstream of the EX/MEM pipeline register.
- Resolves branches, drives the data-memory bus through a req/ready handshake, and stalls the pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register that feeds write-back.

Parameters:
- TIMEOUT, 15: number of WAIT cycles without dmem_ready before the access is aborted with a bus error.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- MEM_Branch  in  1  branch instruction in MEM
- MEM_MemRead  in  1  load in MEM
- MEM_MemWrite  in  1  store in MEM
- MEM_MemtoReg  in  1  WB selects memory data
- MEM_RegWrite  in  1  instruction writes the register file
- EXtoMEM_zero  in  1  ALU zero flag
- EXtoMEM_ALUresult  in  32  ALU result / memory address
- EXtoMEM_ReadData2  in  32  store data
- EXtoMEM_Branch_Addr  in  32  branch target
- EXtoMEM_RegDest  in  5  destination register
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  32  word address, registered
- dmem_wdata  out  32  write data, registered
- dmem_ready  in  1  access complete (read data valid this cycle)
- dmem_rdata  in  32  read data
- pc_src  out  1  take branch (combinational)
- branch_target  out  32  equals EXtoMEM_Branch_Addr (combinational)
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM (combinational)
- MEMtoWB_ReadData  out  32  registered load data
- MEMtoWB_ALUresult  out  32  registered ALU result
- MEMtoWB_RegDest  out  5  registered destination register
- WB_MemtoReg  out  1  registered control
- WB_RegWrite  out  1  registered control
- misalign_err  out  1  sticky: misaligned access seen
- bus_err  out  1  sticky: access timed out

Behaviour:
- Reset:
  - Synchronous, checked first on every edge; overrides everything.
  - State goes to IDLE and the timeout counter clears.
  - All registered outputs go to 0: dmem_*, MEMtoWB_*, WB_*, and both sticky error flags.
  - Reset during WAIT drops dmem_req at that edge with no completion. The memory side ignores a late dmem_ready.
- Definitions:
  - access = MEM_MemRead | MEM_MemWrite.
  - mis = access & (EXtoMEM_ALUresult[1:0] != 0).
  - MemWrite has priority: if both read and write are set, the instruction is treated as a store.
- pc_src = MEM_Branch & EXtoMEM_zero. It is independent of the FSM; branches never access memory.
- FSM states: IDLE and WAIT.
- IDLE with no access, or with mis:
  - mem_stall = 0.
  - MEM/WB captures at the edge: ALUresult, RegDest, MemtoReg, RegWrite; ReadData <= 0.
  - If mis: WB_RegWrite <= 0, misalign_err <= 1, no bus request.
- IDLE with aligned access:
  - mem_stall = 1.
  - At the edge: dmem_req <= 1, dmem_we <= MEM_MemWrite, dmem_addr <= ALUresult, dmem_wdata <= ReadData2, counter <= 0.
  - MEM/WB loads a bubble (WB_RegWrite <= 0, WB_MemtoReg <= 0).
  - Next state: WAIT.
- WAIT with dmem_ready = 0:
  - mem_stall = 1.
  - dmem_* held stable; counter increments; MEM/WB keeps loading bubbles.
  - When counter reaches TIMEOUT-1 without ready: dmem_req <= 0, bus_err <= 1, next state IDLE. MEM/WB completes the instruction with ReadData 0 and WB_RegWrite 0. mem_stall = 0 in that cycle.
- WAIT with dmem_ready = 1:
  - mem_stall = 0.
  - At the edge: dmem_req <= 0, MEMtoWB_ReadData <= dmem_rdata (reads) or 0 (writes), the rest of MEM/WB captured normally, next state IDLE.
- Minimum load/store occupancy: 2 cycles. Request issues on the edge after the instruction enters MEM; ready is sampled from the next cycle onward.
- Upstream stages hold the EX/MEM contents stable while mem_stall = 1. This block does not re-latch its inputs.
- Sticky error flags clear only on rst.

Test Plan:
- Reset: assert rst for 2 cycles mid-WAIT → next cycle dmem_req = 0, WB_RegWrite = 0, all MEMtoWB_* = 0, state IDLE.
- ALU op: RegWrite = 1, ALUresult = 0x00001234, RegDest = 5 → after 1 edge MEMtoWB_ALUresult = 0x1234, RegDest = 5, WB_RegWrite = 1, dmem_req never asserted.
- Load: MemRead = 1, MemtoReg = 1, ALUresult = 0x40, ready after 2 WAIT cycles with rdata = 0xDEADBEEF →
  - mem_stall high for 3 cycles;
  - dmem_addr = 0x40, dmem_we = 0;
  - MEMtoWB_ReadData = 0xDEADBEEF, WB_RegWrite = 1 after completion.
- Store: MemWrite = 1, ALUresult = 0x80, ReadData2 = 0xA5A5A5A5, ready on first WAIT cycle → dmem_we = 1, dmem_wdata = 0xA5A5A5A5, stall for exactly 1 cycle.
- Branch: Branch = 1, zero = 1, Branch_Addr = 0x100 → pc_src = 1, branch_target = 0x100 in the same cycle; with zero = 0, pc_src = 0.
- Errors:
  - Load at address 0x42 → no request, misalign_err = 1, WB_RegWrite = 0.
  - Load with ready held low → bus_err = 1 after TIMEOUT (15) WAIT cycles, dmem_req drops, pipeline resumes.

Source files
------------

// File: rtl/mem_stage_unit.sv
// MEM stage: branch resolve, data-memory req/ready access with timeout, MEM/WB register.
// Latency 1 cycle for non-memory ops, >=2 for loads/stores; mem_stall holds upstream while the bus is busy.
module mem_stage_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Branch,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_RegWrite,
    input  logic        EXtoMEM_zero,
    input  logic [31:0] EXtoMEM_ALUresult,
    input  logic [31:0] EXtoMEM_ReadData2,
    input  logic [31:0] EXtoMEM_Branch_Addr,
    input  logic [4:0]  EXtoMEM_RegDest,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        mem_stall,
    output logic [31:0] MEMtoWB_ReadData,
    output logic [31:0] MEMtoWB_ALUresult,
    output logic [4:0]  MEMtoWB_RegDest,
    output logic        WB_MemtoReg,
    output logic        WB_RegWrite,
    output logic        misalign_err,
    output logic        bus_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d, we_q, we_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0]   wb_rdata_q, wb_rdata_d, wb_alu_q, wb_alu_d;
    logic [4:0]    wb_dest_q, wb_dest_d;
    logic          wb_m2r_q, wb_m2r_d, wb_rw_q, wb_rw_d;
    logic          mis_err_q, mis_err_d, bus_err_q, bus_err_d;
    logic          access, mis;

    assign access        = MEM_MemRead | MEM_MemWrite;
    assign mis           = access & (EXtoMEM_ALUresult[1:0] != 2'b00);
    assign pc_src        = MEM_Branch & EXtoMEM_zero;
    assign branch_target = EXtoMEM_Branch_Addr;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wb_rdata_d = wb_rdata_q;
        wb_alu_d   = wb_alu_q;
        wb_dest_d  = wb_dest_q;
        wb_m2r_d   = wb_m2r_q;
        wb_rw_d    = wb_rw_q;
        mis_err_d  = mis_err_q;
        bus_err_d  = bus_err_q;
        mem_stall  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access && !mis) begin
                    mem_stall = 1'b1;
                    req_d     = 1'b1;
                    we_d      = MEM_MemWrite;
                    addr_d    = EXtoMEM_ALUresult;
                    wdata_d   = EXtoMEM_ReadData2;
                    cnt_d     = '0;
                    wb_m2r_d  = 1'b0;
                    wb_rw_d   = 1'b0;
                    state_d   = S_WAIT;
                end else begin
                    wb_rdata_d = 32'd0;
                    wb_alu_d   = EXtoMEM_ALUresult;
                    wb_dest_d  = EXtoMEM_RegDest;
                    wb_m2r_d   = MEM_MemtoReg;
                    wb_rw_d    = MEM_RegWrite & ~mis;
                    if (mis) begin
                        mis_err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    req_d      = 1'b0;
                    wb_rdata_d = MEM_MemWrite ? 32'd0 : dmem_rdata;
                    wb_alu_d   = EXtoMEM_ALUresult;
                    wb_dest_d  = EXtoMEM_RegDest;
                    wb_m2r_d   = MEM_MemtoReg;
                    wb_rw_d    = MEM_RegWrite;
                    state_d    = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Abort: retire the instruction without a register write.
                    req_d      = 1'b0;
                    bus_err_d  = 1'b1;
                    wb_rdata_d = 32'd0;
                    wb_alu_d   = EXtoMEM_ALUresult;
                    wb_dest_d  = EXtoMEM_RegDest;
                    wb_m2r_d   = MEM_MemtoReg;
                    wb_rw_d    = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                    wb_m2r_d  = 1'b0;
                    wb_rw_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wb_rdata_q <= 32'd0;
            wb_alu_q   <= 32'd0;
            wb_dest_q  <= 5'd0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
            mis_err_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wb_rdata_q <= wb_rdata_d;
            wb_alu_q   <= wb_alu_d;
            wb_dest_q  <= wb_dest_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rw_q    <= wb_rw_d;
            mis_err_q  <= mis_err_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign dmem_req          = req_q;
    assign dmem_we           = we_q;
    assign dmem_addr         = addr_q;
    assign dmem_wdata        = wdata_q;
    assign MEMtoWB_ReadData  = wb_rdata_q;
    assign MEMtoWB_ALUresult = wb_alu_q;
    assign MEMtoWB_RegDest   = wb_dest_q;
    assign WB_MemtoReg       = wb_m2r_q;
    assign WB_RegWrite       = wb_rw_q;
    assign misalign_err      = mis_err_q;
    assign bus_err           = bus_err_q;
endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: driver queues expected MEM/WB and bus results, monitor checks them.
module tb_mem_stage_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite, EXtoMEM_zero;
    logic [31:0] EXtoMEM_ALUresult, EXtoMEM_ReadData2, EXtoMEM_Branch_Addr;
    logic [4:0]  EXtoMEM_RegDest;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        pc_src, mem_stall;
    logic [31:0] branch_target, MEMtoWB_ReadData, MEMtoWB_ALUresult;
    logic [4:0]  MEMtoWB_RegDest;
    logic        WB_MemtoReg, WB_RegWrite, misalign_err, bus_err;

    mem_stage_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .MEM_Branch(MEM_Branch), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite), .EXtoMEM_zero(EXtoMEM_zero),
        .EXtoMEM_ALUresult(EXtoMEM_ALUresult), .EXtoMEM_ReadData2(EXtoMEM_ReadData2),
        .EXtoMEM_Branch_Addr(EXtoMEM_Branch_Addr), .EXtoMEM_RegDest(EXtoMEM_RegDest),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .pc_src(pc_src), .branch_target(branch_target), .mem_stall(mem_stall),
        .MEMtoWB_ReadData(MEMtoWB_ReadData), .MEMtoWB_ALUresult(MEMtoWB_ALUresult),
        .MEMtoWB_RegDest(MEMtoWB_RegDest), .WB_MemtoReg(WB_MemtoReg), .WB_RegWrite(WB_RegWrite),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  dest;
        logic        m2r;
        logic        rw;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    int       checks   = 0;
    int       failures = 0;
    logic     instr_vld = 1'b0;
    logic     req_seen  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: bus handshakes checked at the negedge, retirements right after the edge.
    initial begin
        logic     ret;
        wb_exp_t  we_x;
        bus_exp_t be_x;
        forever begin
            @(negedge clk);
            if (dmem_req) req_seen = 1'b1;
            ret = !rst && instr_vld && !mem_stall;
            if (!rst && dmem_req && dmem_ready) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_handshake", 32'd1, 32'd0);
                end else begin
                    be_x = bus_q.pop_front();
                    chk("bus_we",    {31'd0, dmem_we}, {31'd0, be_x.we});
                    chk("bus_addr",  dmem_addr,  be_x.addr);
                    chk("bus_wdata", dmem_wdata, be_x.wdata);
                end
            end
            @(posedge clk);
            #1;
            if (ret) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    we_x = wb_q.pop_front();
                    chk("wb_readdata", MEMtoWB_ReadData,  we_x.rdata);
                    chk("wb_alu",      MEMtoWB_ALUresult, we_x.alu);
                    chk("wb_dest",     {27'd0, MEMtoWB_RegDest}, {27'd0, we_x.dest});
                    chk("wb_memtoreg", {31'd0, WB_MemtoReg}, {31'd0, we_x.m2r});
                    chk("wb_regwrite", {31'd0, WB_RegWrite}, {31'd0, we_x.rw});
                end
            end
        end
    end

    task automatic clear_inputs();
        MEM_Branch = 0; MEM_MemRead = 0; MEM_MemWrite = 0; MEM_MemtoReg = 0; MEM_RegWrite = 0;
        EXtoMEM_zero = 0; EXtoMEM_ALUresult = 0; EXtoMEM_ReadData2 = 0; EXtoMEM_Branch_Addr = 0;
        EXtoMEM_RegDest = 0; dmem_ready = 0; dmem_rdata = 0;
    endtask

    task automatic drive(input logic mr, input logic mw, input logic m2r, input logic rw,
                         input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] dest);
        MEM_MemRead = mr; MEM_MemWrite = mw; MEM_MemtoReg = m2r; MEM_RegWrite = rw;
        EXtoMEM_ALUresult = alu; EXtoMEM_ReadData2 = rd2; EXtoMEM_RegDest = dest;
    endtask

    // Called 2 time units after a rising edge; returns at the same phase once the instruction retires.
    // ready_after = number of WAIT cycles with ready low before ready (-1: never).
    task automatic run_instr(input string name, input int ready_after, input logic [31:0] rdata,
                             input int exp_stall);
        int  stalls = 0;
        bit  done   = 0;
        logic st;
        instr_vld = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            dmem_ready = (ready_after >= 0) && (c == ready_after + 1);
            dmem_rdata = rdata;
            @(negedge clk);
            st = mem_stall;
            if (st) stalls++;
            @(posedge clk);
            #2;
            if (!st) done = 1;
        end
        instr_vld = 1'b0;
        clear_inputs();
        if (!done) chk({name, "_retire_timeout"}, 32'd0, 32'd1);
        chk({name, "_stall_cycles"}, stalls, exp_stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dmem_req",  {31'd0, dmem_req}, 32'd0);
        chk("rst_wb_rw",     {31'd0, WB_RegWrite}, 32'd0);
        chk("rst_wb_alu",    MEMtoWB_ALUresult, 32'd0);
        chk("rst_errs",      {30'd0, misalign_err, bus_err}, 32'd0);
        chk("rst_stall",     {31'd0, mem_stall}, 32'd0);
        @(posedge clk);
        #2;

        // ALU op: one-cycle pass-through, no bus activity.
        req_seen = 1'b0;
        drive(0, 0, 0, 1, 32'h0000_1234, 32'h0, 5'd5);
        wb_q.push_back('{rdata: 32'h0, alu: 32'h1234, dest: 5'd5, m2r: 1'b0, rw: 1'b1});
        run_instr("alu", -1, 32'h0, 0);
        chk("alu_no_req", {31'd0, req_seen}, 32'd0);

        // Branch resolution is combinational.
        MEM_Branch = 1; EXtoMEM_zero = 1; EXtoMEM_Branch_Addr = 32'h100;
        #1;
        chk("br_taken",  {31'd0, pc_src}, 32'd1);
        chk("br_target", branch_target, 32'h100);
        chk("br_nostall", {31'd0, mem_stall}, 32'd0);
        EXtoMEM_zero = 0;
        #1;
        chk("br_not_taken", {31'd0, pc_src}, 32'd0);
        clear_inputs();
        @(posedge clk);
        #2;

        // Load, ready after 2 WAIT cycles.
        drive(1, 0, 1, 1, 32'h40, 32'h1111_2222, 5'd7);
        bus_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h1111_2222});
        wb_q.push_back('{rdata: 32'hDEAD_BEEF, alu: 32'h40, dest: 5'd7, m2r: 1'b1, rw: 1'b1});
        run_instr("load", 2, 32'hDEAD_BEEF, 3);

        // Store, ready on first WAIT cycle; read data must not leak into WB.
        drive(0, 1, 0, 0, 32'h80, 32'hA5A5_A5A5, 5'd0);
        bus_q.push_back('{we: 1'b1, addr: 32'h80, wdata: 32'hA5A5_A5A5});
        wb_q.push_back('{rdata: 32'h0, alu: 32'h80, dest: 5'd0, m2r: 1'b0, rw: 1'b0});
        run_instr("store", 0, 32'h1234_5678, 1);

        // Read and write both set: behaves as a store.
        drive(1, 1, 0, 0, 32'hC0, 32'h0F0F_0F0F, 5'd4);
        bus_q.push_back('{we: 1'b1, addr: 32'hC0, wdata: 32'h0F0F_0F0F});
        wb_q.push_back('{rdata: 32'h0, alu: 32'hC0, dest: 5'd4, m2r: 1'b0, rw: 1'b0});
        run_instr("rw_both", 1, 32'hFFFF_0000, 2);

        // Misaligned load: no request, write suppressed, sticky flag.
        req_seen = 1'b0;
        drive(1, 0, 1, 1, 32'h42, 32'h0, 5'd9);
        wb_q.push_back('{rdata: 32'h0, alu: 32'h42, dest: 5'd9, m2r: 1'b1, rw: 1'b0});
        run_instr("misalign", -1, 32'h0, 0);
        chk("mis_no_req",  {31'd0, req_seen}, 32'd0);
        chk("mis_flag",    {31'd0, misalign_err}, 32'd1);
        chk("mis_no_bus_err", {31'd0, bus_err}, 32'd0);

        // Load that never completes: aborts after 15 WAIT cycles.
        drive(1, 0, 1, 1, 32'h100, 32'h0, 5'd3);
        wb_q.push_back('{rdata: 32'h0, alu: 32'h100, dest: 5'd3, m2r: 1'b1, rw: 1'b0});
        run_instr("timeout", -1, 32'h5555_5555, 15);
        @(negedge clk);
        chk("to_bus_err",   {31'd0, bus_err}, 32'd1);
        chk("to_req_drop",  {31'd0, dmem_req}, 32'd0);
        chk("to_mis_sticky", {31'd0, misalign_err}, 32'd1);
        @(posedge clk);
        #2;

        // Pipeline resumes after the abort.
        drive(0, 0, 0, 1, 32'hBEEF, 32'h0, 5'd12);
        wb_q.push_back('{rdata: 32'h0, alu: 32'hBEEF, dest: 5'd12, m2r: 1'b0, rw: 1'b1});
        run_instr("resume", -1, 32'h0, 0);

        // Reset in the middle of WAIT.
        drive(1, 0, 1, 1, 32'h200, 32'h0, 5'd6);
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        chk("mid_rst_req",   {31'd0, dmem_req}, 32'd0);
        chk("mid_rst_rw",    {31'd0, WB_RegWrite}, 32'd0);
        chk("mid_rst_m2r",   {31'd0, WB_MemtoReg}, 32'd0);
        chk("mid_rst_alu",   MEMtoWB_ALUresult, 32'd0);
        chk("mid_rst_rdata", MEMtoWB_ReadData, 32'd0);
        chk("mid_rst_dest",  {27'd0, MEMtoWB_RegDest}, 32'd0);
        chk("mid_rst_errs",  {30'd0, misalign_err, bus_err}, 32'd0);
        chk("mid_rst_idle",  {31'd0, mem_stall}, 32'd0);
        @(posedge clk);
        #2;

        // Load after reset with immediate ready.
        drive(1, 0, 1, 1, 32'h44, 32'h0, 5'd2);
        bus_q.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0});
        wb_q.push_back('{rdata: 32'hCAFE_F00D, alu: 32'h44, dest: 5'd2, m2r: 1'b1, rw: 1'b1});
        run_instr("post_rst_load", 0, 32'hCAFE_F00D, 1);

        repeat (2) @(posedge clk);
        #2;
        chk("wb_queue_drained",  wb_q.size(), 32'd0);
        chk("bus_queue_drained", bus_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
